interrupt_controller_v2: RTL

Parametrised successor to the 8-input 6502 interrupt aggregator. Collects N_IRQ active-low requests from on-chip peripherals and applies per-source enable and per-source level/edge mode. Edge requests latch into write-1-to-clear pending bits. Drives a single active-low irqb_master to the CPU and exposes all state through an 8-bit memory-mapped register window on the CPU bus.

---
 rtl/interrupt_controller_v2.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/interrupt_controller_v2.sv
// interrupt_controller_v2: aggregates N_IRQ active-low requests into one
// active-low CPU interrupt with per-source enable, level/edge mode and
// write-1-to-clear pending bits, behind an 8-bit register window.
// Register address = {0, reg[1:0], bank[1:0]}; 0x10 ID, 0x11 CTRL (GIE).
// Optional macro INTCTRL_PRIORITY_EN adds a registered lowest-index
// priority encoder readable at ID; without it ID reads 0x00.
// Bus handshake: a CPU access happens whenever cs is high; rwb=1 reads
// combinationally with no side effects, rwb=0 commits the write at the
// next rising clk edge. There is no stall: every access completes at once.
module interrupt_controller_v2 #(
    parameter int N_IRQ = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       addr,
    input  logic [7:0]       i_data,
    output logic [7:0]       o_data,
    input  logic             cs,
    input  logic             rwb,
    input  logic [N_IRQ-1:0] irqb_in,
    output logic             irqb_master
);

    localparam logic [1:0] REG_RAW     = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_MODE    = 2'd2;
    localparam logic [1:0] REG_PENDING = 2'd3;
    localparam logic [4:0] ADDR_ID     = 5'h10;
    localparam logic [4:0] ADDR_CTRL   = 5'h11;

    logic [N_IRQ-1:0] enable_q,  enable_d;
    logic [N_IRQ-1:0] mode_q,    mode_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] prev_q,    prev_d;
    logic             gie_q,     gie_d;
    logic             irqb_master_q, irqb_master_d;
    logic [7:0]       id_q,      id_d;

    logic             wr;
    logic             bank_space;
    logic [1:0]       reg_idx;
    logic [1:0]       bank;
    logic [N_IRQ-1:0] wmask;
    logic [N_IRQ-1:0] wdata;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] fall;
    logic [N_IRQ-1:0] mode_chg;
    logic [N_IRQ-1:0] active;

    // Extract the 8-bit slice of a source vector for one bank; bits past N_IRQ read 0.
    function automatic logic [7:0] bank_byte(input logic [N_IRQ-1:0] v, input logic [1:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < N_IRQ; i++) begin
            if ((i / 8) == int'(b)) r[i % 8] = v[i];
        end
        return r;
    endfunction

    // Bus decode: spread the write byte onto the selected bank's source lanes.
    always_comb begin
        wr         = cs & ~rwb;
        bank_space = ~addr[4];
        reg_idx    = addr[3:2];
        bank       = addr[1:0];
        wmask      = '0;
        wdata      = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            wmask[i] = ((i / 8) == int'(bank));
            wdata[i] = i_data[i % 8];
        end
    end

    // Next-state for enable, mode, pending, edge history and GIE.
    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        gie_d    = gie_q;
        prev_d   = irqb_in;
        clr      = '0;
        if (wr && bank_space && reg_idx == REG_ENABLE)
            enable_d = (enable_q & ~wmask) | (wdata & wmask);
        if (wr && bank_space && reg_idx == REG_MODE)
            mode_d = (mode_q & ~wmask) | (wdata & wmask);
        if (wr && bank_space && reg_idx == REG_PENDING)
            clr = wdata & wmask;
        if (wr && addr == ADDR_CTRL)
            gie_d = i_data[0];
        fall     = prev_q & ~irqb_in;
        mode_chg = mode_d ^ mode_q;
        // A new edge beats a same-cycle clear; a mode flip discards stale state.
        for (int i = 0; i < N_IRQ; i++) begin
            if (mode_chg[i])
                pending_d[i] = 1'b0;
            else if (mode_q[i])
                pending_d[i] = fall[i] | (pending_q[i] & ~clr[i]);
            else
                pending_d[i] = ~irqb_in[i];
        end
        active        = pending_q & enable_q;
        irqb_master_d = ~(gie_q & (|active));
    end

`ifdef INTCTRL_PRIORITY_EN
    // Lowest active index wins; 0x80 means nothing is both pending and enabled.
    always_comb begin
        id_d = 8'h80;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (active[i]) id_d = 8'(i);
        end
    end
`else
    // No encoder: ID is a constant zero.
    always_comb begin
        id_d = 8'h00;
    end
`endif

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q      <= '0;
            mode_q        <= '0;
            pending_q     <= '0;
            prev_q        <= '1;
            gie_q         <= 1'b1;
            irqb_master_q <= 1'b1;
`ifdef INTCTRL_PRIORITY_EN
            id_q          <= 8'h80;
`else
            id_q          <= 8'h00;
`endif
        end else begin
            enable_q      <= enable_d;
            mode_q        <= mode_d;
            pending_q     <= pending_d;
            prev_q        <= prev_d;
            gie_q         <= gie_d;
            irqb_master_q <= irqb_master_d;
            id_q          <= id_d;
        end
    end

    // Read mux: combinational, zero unless a read is selected.
    always_comb begin
        o_data = 8'h00;
        if (cs && rwb) begin
            if (bank_space) begin
                case (reg_idx)
                    REG_RAW:     o_data = bank_byte(~irqb_in, bank);
                    REG_ENABLE:  o_data = bank_byte(enable_q, bank);
                    REG_MODE:    o_data = bank_byte(mode_q, bank);
                    REG_PENDING: o_data = bank_byte(pending_q, bank);
                    default:     o_data = 8'h00;
                endcase
            end else if (addr == ADDR_ID) begin
                o_data = id_q;
            end else if (addr == ADDR_CTRL) begin
                o_data = {7'b0, gie_q};
            end
        end
    end

    assign irqb_master = irqb_master_q;

endmodule
